// File: rtl/spi_slave_responder.sv
// SPI slave with oversampled SCLK/SS_N/MOSI, one-entry TX buffer (valid/ready) and pulsed RX word output.
// Build option: define SPI_SLAVE_LSB_FIRST_EN for LSB-first TX and RX; default build is MSB first.
module spi_slave_responder #(
    parameter int                    DATA_WIDTH = 8,
    parameter bit                    CPOL       = 1'b0,
    parameter bit                    CPHA       = 1'b0,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_TX = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk_i,
    input  logic                  ss_n_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  tx_underrun_o,
    output logic                  frame_abort_o,
    output logic                  busy_o
);
    localparam int              CW       = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic [0:0]      S_IDLE   = 1'b0;
    localparam logic [0:0]      S_ACTIVE = 1'b1;

    logic                  r_sclk_meta, r_sclk_sync, r_sclk_d;
    logic                  r_ss_meta, r_ss_sync, r_ss_d;
    logic                  r_mosi_meta, r_mosi_sync;
    logic [0:0]            r_state;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_rx_shift, r_rx_data, r_tx_shift, r_buf;
    logic                  r_rx_done, r_rx_valid, r_abort, r_underrun;
    logic                  r_load_pend, r_skip, r_buf_full;

    logic                  w_sclk_rise, w_sclk_fall, w_lead, w_trail, w_sample, w_shift;
    logic                  w_ss_fall, w_ss_rise, w_active, w_load, w_accept, w_tx_bit;
    logic [DATA_WIDTH-1:0] w_tx_shifted, w_rx_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_meta <= CPOL;
            r_sclk_sync <= CPOL;
            r_sclk_d    <= CPOL;
            // Select sync resets low: a select still held low after reset never reads as a fresh fall.
            r_ss_meta   <= 1'b0;
            r_ss_sync   <= 1'b0;
            r_ss_d      <= 1'b0;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_sclk_meta <= sclk_i;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_d    <= r_sclk_sync;
            r_ss_meta   <= ss_n_i;
            r_ss_sync   <= r_ss_meta;
            r_ss_d      <= r_ss_sync;
            r_mosi_meta <= mosi_i;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    assign w_sclk_rise = r_sclk_sync & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_sync & r_sclk_d;
    assign w_lead      = CPOL ? w_sclk_fall : w_sclk_rise;
    assign w_trail     = CPOL ? w_sclk_rise : w_sclk_fall;
    assign w_sample    = CPHA ? w_trail : w_lead;
    assign w_shift     = CPHA ? w_lead : w_trail;
    assign w_ss_fall   = ~r_ss_sync & r_ss_d;
    assign w_ss_rise   = r_ss_sync & ~r_ss_d;
    assign w_active    = (r_state == S_ACTIVE);
    assign w_accept    = tx_valid_i & ~r_buf_full;
    // A pending load replaces the shift on the first shift edge of the next word.
    assign w_load      = (~w_active & w_ss_fall) |
                         (w_active & ~w_ss_rise & w_shift & r_load_pend);

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign w_tx_shifted = {1'b0, r_tx_shift[DATA_WIDTH-1:1]};
    assign w_rx_next    = {r_mosi_sync, r_rx_shift[DATA_WIDTH-1:1]};
    assign w_tx_bit     = r_tx_shift[0];
`else
    assign w_tx_shifted = {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
    assign w_rx_next    = {r_rx_shift[DATA_WIDTH-2:0], r_mosi_sync};
    assign w_tx_bit     = r_tx_shift[DATA_WIDTH-1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_rx_done   <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_abort     <= 1'b0;
            r_load_pend <= 1'b0;
            r_skip      <= 1'b0;
        end else begin
            r_rx_done  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_abort    <= 1'b0;
            if (r_rx_done) begin
                r_rx_data  <= r_rx_shift;
                r_rx_valid <= 1'b1;
            end
            if (!w_active) begin
                if (w_ss_fall) begin
                    r_state <= S_ACTIVE;
                    // CPHA=1: bit 0 is already on MISO, so the first leading edge must hold it.
                    r_skip  <= CPHA;
                end
            end else if (w_ss_rise) begin
                r_state     <= S_IDLE;
                r_cnt       <= '0;
                r_load_pend <= 1'b0;
                r_skip      <= 1'b0;
                r_abort     <= (r_cnt != '0);
            end else begin
                if (w_sample) begin
                    r_rx_shift <= w_rx_next;
                    if (r_cnt == LAST_BIT) begin
                        r_cnt       <= '0;
                        r_rx_done   <= 1'b1;
                        r_load_pend <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                if (w_shift) begin
                    if (r_load_pend)
                        r_load_pend <= 1'b0;
                    else if (r_skip)
                        r_skip <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_shift <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_accept)
                r_buf <= tx_data_i;
            if (w_load) begin
                // Load sees the old buffer; a same-cycle accept refills it.
                r_buf_full <= w_accept;
                if (r_buf_full) begin
                    r_tx_shift <= r_buf;
                end else begin
                    r_tx_shift <= DEFAULT_TX;
                    r_underrun <= 1'b1;
                end
            end else begin
                if (w_accept)
                    r_buf_full <= 1'b1;
                if (w_active && !w_ss_rise && w_shift && !r_skip)
                    r_tx_shift <= w_tx_shifted;
            end
        end
    end

    assign miso_o        = w_active & w_tx_bit;
    assign miso_oe_o     = w_active;
    assign busy_o        = w_active;
    assign tx_ready_o    = ~r_buf_full;
    assign rx_data_o     = r_rx_data;
    assign rx_valid_o    = r_rx_valid;
    assign tx_underrun_o = r_underrun;
    assign frame_abort_o = r_abort;
endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: instance 0 in mode 0 (DEFAULT_TX=0xFF), instance 1 in mode 3 (DEFAULT_TX=0x00).
// Received words are scoreboarded; MISO words, pulses and latencies are checked per frame.
module tb_spi_slave_responder;
`ifdef SPI_SLAVE_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif
    localparam int       HALF   = 5;
    localparam bit [1:0] CPOL_V = 2'b10;
    localparam bit [1:0] CPHA_V = 2'b10;

    typedef struct {
        int         d;
        logic [7:0] w;
    } rx_t;

    typedef struct {
        bit         pre;
        logic [7:0] tx;
        logic [7:0] mo;
        logic [7:0] exp_mi;
        int         exp_und;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sclk, ss_n, mosi, tv;
    logic [1:0] miso, oe, rdy, rxv, und, abt, busy;
    logic [7:0] td  [2];
    logic [7:0] rxd [2];

    rx_t  sb[$];
    vec_t vt [6];
    int   n_cmp = 0, n_bad = 0, cyc = 0, samp_cyc = 0;
    int   rx_cyc [2], rx_cnt [2], und_cnt [2], ab_cnt [2];

    always #5 clk = ~clk;

    spi_slave_responder #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .DEFAULT_TX(8'hFF)) u_m0 (
        .clk(clk), .rst(rst), .sclk_i(sclk[0]), .ss_n_i(ss_n[0]), .mosi_i(mosi[0]),
        .miso_o(miso[0]), .miso_oe_o(oe[0]), .tx_data_i(td[0]), .tx_valid_i(tv[0]),
        .tx_ready_o(rdy[0]), .rx_data_o(rxd[0]), .rx_valid_o(rxv[0]), .tx_underrun_o(und[0]),
        .frame_abort_o(abt[0]), .busy_o(busy[0]));

    spi_slave_responder #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .DEFAULT_TX(8'h00)) u_m3 (
        .clk(clk), .rst(rst), .sclk_i(sclk[1]), .ss_n_i(ss_n[1]), .mosi_i(mosi[1]),
        .miso_o(miso[1]), .miso_oe_o(oe[1]), .tx_data_i(td[1]), .tx_valid_i(tv[1]),
        .tx_ready_o(rdy[1]), .rx_data_o(rxd[1]), .rx_valid_o(rxv[1]), .tx_underrun_o(und[1]),
        .frame_abort_o(abt[1]), .busy_o(busy[1]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every clock is observed here, so pulses and RX words are never missed.
    task automatic tick(input int n);
        rx_t e;
        repeat (n) begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (rxv[d] === 1'b1) begin
                    rx_cyc[d] = cyc;
                    rx_cnt[d]++;
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL rx_unexpected: dut %0d got %h expected none", d, rxd[d]);
                    end else begin
                        e = sb.pop_front();
                        check("rx_dut", 32'(d), 32'(e.d));
                        check("rx_data", 32'(rxd[d]), 32'(e.w));
                    end
                end
                if (und[d] === 1'b1) und_cnt[d]++;
                if (abt[d] === 1'b1) ab_cnt[d]++;
            end
        end
    endtask

    task automatic check_reset(input int d);
        check("rst_miso", 32'(miso[d]), 0);
        check("rst_oe", 32'(oe[d]), 0);
        check("rst_busy", 32'(busy[d]), 0);
        check("rst_rxv", 32'(rxv[d]), 0);
        check("rst_und", 32'(und[d]), 0);
        check("rst_abt", 32'(abt[d]), 0);
        check("rst_rxd", 32'(rxd[d]), 0);
        check("rst_rdy", 32'(rdy[d]), 1);
    endtask

    task automatic tx_push(input int d, input logic [7:0] w);
        int k = 0;
        while (rdy[d] !== 1'b1 && k < 50) begin
            tick(1);
            k++;
        end
        if (rdy[d] !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx_ready_timeout: got %b expected 1", rdy[d]);
        end
        td[d] = w;
        tv[d] = 1'b1;
        tick(1);
        tv[d] = 1'b0;
        check("tx_ready_fall", 32'(rdy[d]), 0);
    endtask

    task automatic ss_fall(input int d);
        ss_n[d] = 1'b0;
        tick(2);
        check("oe_early", 32'(oe[d]), 0);
        tick(1);
        check("oe_3clk", 32'(oe[d]), 1);
        tick(HALF);
    endtask

    task automatic ss_rise(input int d);
        tick(HALF);
        ss_n[d] = 1'b1;
        tick(HALF);
    endtask

    task automatic word(input int d, input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        int b;
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            b = LSB ? i : 7 - i;
            if (CPHA_V[d] == 1'b0) begin
                mosi[d] = mo[b];
                tick(HALF);
                sclk[d] = ~CPOL_V[d];
                samp_cyc = cyc;
                mi[b] = miso[d];
                tick(HALF);
                sclk[d] = CPOL_V[d];
            end else begin
                sclk[d] = ~CPOL_V[d];
                mosi[d] = mo[b];
                tick(HALF);
                sclk[d] = CPOL_V[d];
                samp_cyc = cyc;
                mi[b] = miso[d];
                tick(HALF);
            end
        end
    endtask

    task automatic frame(input int d, input bit pre, input logic [7:0] tx, input logic [7:0] mo,
                         input logic [7:0] exp_mi, input int exp_und);
        logic [7:0] mi;
        int u0 = und_cnt[d];
        int r0 = rx_cnt[d];
        if (pre) tx_push(d, tx);
        ss_fall(d);
        sb.push_back('{d, mo});
        word(d, mo, 8, mi);
        ss_rise(d);
        check("miso_word", 32'(mi), 32'(exp_mi));
        check("rx_count", 32'(rx_cnt[d] - r0), 1);
        check("rx_latency", 32'(rx_cyc[d] - samp_cyc), 4);
        check("rx_hold", 32'(rxd[d]), 32'(mo));
        check("underruns", 32'(und_cnt[d] - u0), 32'(exp_und));
        check("tx_ready_idle", 32'(rdy[d]), 1);
    endtask

    initial begin
        logic [7:0] mi, mi2, prev, mask;
        int u0, r0, a0;
        // Mode 0 also reloads on the trailing edge after bit 8, which underruns with an empty buffer.
        vt[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 1};
        vt[1] = '{1'b1, 8'h00, 8'hFF, 8'h00, 1};
        vt[2] = '{1'b0, 8'h00, 8'h55, 8'hFF, 2};
        vt[3] = '{1'b1, 8'h5A, 8'h81, 8'h5A, 1};
        vt[4] = '{1'b1, 8'h01, 8'h80, 8'h01, 1};
        vt[5] = '{1'b1, 8'hC3, 8'h0F, 8'hC3, 1};
        for (int d = 0; d < 2; d++) begin
            rx_cyc[d] = 0; rx_cnt[d] = 0; und_cnt[d] = 0; ab_cnt[d] = 0; td[d] = 8'h00;
        end
        rst = 1'b1; sclk = CPOL_V; ss_n = 2'b11; mosi = 2'b00; tv = 2'b00;
        tick(3);
        check_reset(0);
        check_reset(1);
        rst = 1'b0;
        tick(4);

        for (int i = 0; i < 6; i++)
            frame(0, vt[i].pre, vt[i].tx, vt[i].mo, vt[i].exp_mi, vt[i].exp_und);

        // Abort after 5 bits: no RX, data held, abort pulses once.
        prev = rxd[0]; r0 = rx_cnt[0]; a0 = ab_cnt[0];
        tx_push(0, 8'h77);
        ss_fall(0);
        word(0, 8'hF0, 5, mi);
        ss_rise(0);
        mask = LSB ? 8'h1F : 8'hF8;
        check("abort_miso", 32'(mi & mask), 32'(8'h77 & mask));
        check("abort_pulse", 32'(ab_cnt[0] - a0), 1);
        check("abort_no_rx", 32'(rx_cnt[0] - r0), 0);
        check("abort_rx_hold", 32'(rxd[0]), 32'(prev));
        check("abort_tx_ready", 32'(rdy[0]), 1);
        frame(0, 1'b1, 8'h3C, 8'hA5, 8'h3C, 1);

        // Reset mid-frame with select held low, then a clocked word that must be ignored.
        tx_push(0, 8'h99);
        ss_fall(0);
        word(0, 8'hAA, 3, mi);
        rst = 1'b1;
        #1;
        check_reset(0);
        tick(2);
        rst = 1'b0;
        tick(2);
        u0 = und_cnt[0]; r0 = rx_cnt[0];
        word(0, 8'hFF, 8, mi);
        check("ghost_miso", 32'(mi), 0);
        check("ghost_busy", 32'(busy[0]), 0);
        check("ghost_oe", 32'(oe[0]), 0);
        check("ghost_und", 32'(und_cnt[0] - u0), 0);
        check("ghost_rx", 32'(rx_cnt[0] - r0), 0);
        check("ghost_rxd", 32'(rxd[0]), 0);
        ss_rise(0);
        frame(0, 1'b1, 8'h5A, 8'hC3, 8'h5A, 1);

        // Mode 3: two back-to-back words in one select.
        u0 = und_cnt[1]; r0 = rx_cnt[1];
        tx_push(1, 8'h12);
        ss_fall(1);
        tx_push(1, 8'h34);
        sb.push_back('{1, 8'hA7});
        word(1, 8'hA7, 8, mi);
        sb.push_back('{1, 8'h5E});
        word(1, 8'h5E, 8, mi2);
        check("b2b_rx_latency", 32'(rx_cyc[1] - samp_cyc), 4);
        ss_rise(1);
        check("b2b_miso0", 32'(mi), 32'(8'h12));
        check("b2b_miso1", 32'(mi2), 32'(8'h34));
        check("b2b_rx_count", 32'(rx_cnt[1] - r0), 2);
        check("b2b_und", 32'(und_cnt[1] - u0), 0);
        check("b2b_tx_ready", 32'(rdy[1]), 1);
        frame(1, 1'b0, 8'h00, 8'h66, 8'h00, 1);
        frame(1, 1'b1, 8'hE1, 8'h18, 8'hE1, 0);

        check("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_slave_responder.md
# spi_slave_responder

Synthesizable SPI slave (responder) for the far end of the bridge's SPI master port: the counterpart that returns MISO data and captures MOSI words issued by the AXI-to-SPI master. All SPI inputs are oversampled in the single system clock domain and exchanged with local logic through a one-entry TX buffer with a valid/ready handshake and a pulsed RX output. It is used as a loopback target in system-level runs and as a reusable peripheral front end.

## Interface

Parameters:
- DATA_WIDTH, 8: bits per SPI word, range 4 to 32.
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 means sample on the leading edge; 1 means sample on the trailing edge.
- DEFAULT_TX, 0: word shifted out on TX underrun.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous and active-high.
- sclk_i  in  1  SPI clock from master; asynchronous to clk.
- ss_n_i  in  1  slave select, active low; asynchronous to clk.
- mosi_i  in  1  master-out data.
- miso_o  out  1  slave-out data.
- miso_oe_o  out  1  MISO output enable; high while the slave is selected.
- tx_data_i  in  DATA_WIDTH  next word to transmit.
- tx_valid_i  in  1  tx_data_i valid.
- tx_ready_o  out  1  TX buffer empty; a transfer occurs when valid and ready are both high.
- rx_data_o  out  DATA_WIDTH  last complete received word; held until the next word completes.
- rx_valid_o  out  1  one-cycle pulse when rx_data_o updates.
- tx_underrun_o  out  1  one-cycle pulse when DEFAULT_TX was loaded.
- frame_abort_o  out  1  one-cycle pulse when ss_n rises mid-word.
- busy_o  out  1  high in ACTIVE.

## Operation

- Synchronization:
  - sclk_i, ss_n_i and mosi_i each pass through a 2-FF synchronizer.
  - Edge detection uses the synchronized value and its registered copy.
  - Requirement: f_clk ≥ 8 × f_sclk.
- Edges:
  - The leading edge is the transition away from the CPOL level; the trailing edge is the return.
  - Sample edge is leading when CPHA=0 and trailing when CPHA=1.
  - The shift edge is the other one.
- FSM IDLE:
  - miso_oe_o=0 and the bit counter is 0.
  - On a synchronized ss_n fall: go to ACTIVE and perform a word load.
- FSM ACTIVE:
  - Sample edge: shift mosi into rx_shift and increment the bit counter.
  - Shift edge: shift tx_shift left, MSB first. When CPHA=1, the first leading edge after a word load does not shift.
  - When the counter reaches DATA_WIDTH on a sample edge:
    - Copy rx_shift, including the bit just sampled, to rx_data_o and pulse rx_valid_o.
    - Reset the counter to 0.
    - Perform a word load at the next shift edge; back-to-back words within one ss_n assertion are supported.
- FSM exit from ACTIVE:
  - On a synchronized ss_n rise: go to IDLE.
  - If the counter is nonzero, pulse frame_abort_o. No rx_valid_o is generated, and rx_data_o keeps its previous value.
  - The TX buffer is not consumed by an aborted word.
- Word load:
  - If the buffer is full: tx_shift ← buffer, and the buffer empties (tx_ready_o=1 next cycle).
  - Otherwise: tx_shift ← DEFAULT_TX and tx_underrun_o pulses.
- miso_o = tx_shift[DATA_WIDTH-1] when miso_oe_o=1, else 0.
- TX buffer:
  - Accepts a word when tx_valid_i && tx_ready_o.
  - If a word load and an accept occur in the same cycle, the load takes the old buffer content and the new word fills the buffer.

## Timing

- Reset values:
  - miso_o, miso_oe_o, rx_valid_o, tx_underrun_o, frame_abort_o and busy_o = 0.
  - rx_data_o = 0 and tx_ready_o = 1.
  - FSM in IDLE, TX buffer empty.
- ss_n fall to miso_oe_o=1 and first MISO bit valid: 3 clk (2 synchronizer stages + 1 register).
- Sample edge on sclk_i to bit captured: 3 clk.
- Final sample edge to rx_valid_o: 4 clk.
- tx_ready_o falls 1 clk after a handshake and rises 1 clk after a word load.
- rst asserted mid-frame:
  - All outputs return to their reset values immediately.
  - After rst is released, the slave waits for a fresh ss_n fall; a held-low ss_n is ignored until it rises.

## Configuration

- SPI_SLAVE_LSB_FIRST_EN:
  - When defined, TX and RX are LSB first: tx_shift shifts right, miso_o = tx_shift[0], and rx_shift fills from the MSB side.
  - When undefined, both TX and RX are MSB first.
  - Latency is identical in both builds.

## Test plan

- Mode 0, 8 bits, TX buffer = 0xA5, master sends 0x3C -> MISO shows 0xA5 MSB first; rx_data_o=0x3C; rx_valid_o pulses once; tx_ready_o returns to 1.
- Mode 3 (CPOL=1, CPHA=1), two back-to-back words in one ss_n assertion, TX 0x12 then 0x34 (second loaded after first tx_ready_o) -> MISO 0x12, 0x34; RX pulses twice with matching master data.
- No TX word loaded, DEFAULT_TX=0xFF -> tx_underrun_o pulses at the ss_n fall; MISO shows 0xFF; RX still captured correctly.
- ss_n released after 5 of 8 bits -> frame_abort_o pulse; no rx_valid_o; rx_data_o unchanged; next full frame returns correct data.
- rst pulsed after 3 bits with ss_n held low -> all outputs at reset values; no activity until ss_n rises and falls again, then a normal transfer.
- Build with SPI_SLAVE_LSB_FIRST_EN, TX 0x01, master sends 0x80 LSB first -> first MISO bit 1; rx_data_o=0x80.
